// File: rtl/io_bus_arbiter.sv
// Arbitrates the controller-port I/O register window between the 68K (M) and the Z80 (Z).
// Define ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise M wins every contest.
//
// state | meaning
// IDLE  | no access in flight; arbitrate pending requests
// ISSUE | IO_SEL raised, one tick of address/data setup
// WAIT  | waiting for IO_DTACK_N or the timeout terminal count
// DONE  | winner's DTACK_N held low until its SEL drops
module io_bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CE,
    input  logic       M_SEL,
    input  logic [3:0] M_A,
    input  logic       M_RNW,
    input  logic [7:0] M_DI,
    output logic [7:0] M_DO,
    output logic       M_DTACK_N,
    input  logic       Z_SEL,
    input  logic [3:0] Z_A,
    input  logic       Z_RNW,
    input  logic [7:0] Z_DI,
    output logic [7:0] Z_DO,
    output logic       Z_DTACK_N,
    output logic       IO_SEL,
    output logic [3:0] IO_A,
    output logic       IO_RNW,
    output logic [7:0] IO_DI,
    input  logic [7:0] IO_DO,
    input  logic       IO_DTACK_N
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            grant_z;
    logic            pick_z;
    logic            win_sel;
    logic            win_acked;
    logic            wait_end;
    logic [7:0]      wait_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic            last_z;

    always_comb begin
        pick_z = Z_SEL && (!M_SEL || !last_z);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_z <= 1'b1;
        end else if (CE && state == IDLE && (M_SEL || Z_SEL)) begin
            last_z <= pick_z;
        end
    end
`else
    always_comb begin
        pick_z = Z_SEL && !M_SEL;
    end
`endif

    assign win_sel   = grant_z ? Z_SEL : M_SEL;
    assign win_acked = grant_z ? !Z_DTACK_N : !M_DTACK_N;
    // An ack on the terminal-count tick still wins: its data is used.
    assign wait_end  = !IO_DTACK_N || (to_cnt == TO_LAST);
    assign wait_data = (!IO_DTACK_N && IO_RNW) ? IO_DO : 8'hFF;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            to_cnt    <= '0;
            grant_z   <= 1'b0;
            M_DTACK_N <= 1'b1;
            Z_DTACK_N <= 1'b1;
            M_DO      <= 8'hFF;
            Z_DO      <= 8'hFF;
            IO_SEL    <= 1'b0;
            IO_A      <= 4'h0;
            IO_RNW    <= 1'b1;
            IO_DI     <= 8'h00;
        end else if (CE) begin
            case (state)
                IDLE: begin
                    if (M_SEL || Z_SEL) begin
                        grant_z <= pick_z;
                        IO_A    <= pick_z ? Z_A   : M_A;
                        IO_RNW  <= pick_z ? Z_RNW : M_RNW;
                        IO_DI   <= pick_z ? Z_DI  : M_DI;
                        IO_SEL  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (wait_end) begin
                        IO_SEL <= 1'b0;
                        state  <= DONE;
                        // A winner that already withdrew is never acknowledged.
                        if (win_sel) begin
                            if (grant_z) begin
                                Z_DTACK_N <= 1'b0;
                                Z_DO      <= wait_data;
                            end else begin
                                M_DTACK_N <= 1'b0;
                                M_DO      <= wait_data;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    if (!win_sel || !win_acked) begin
                        M_DTACK_N <= 1'b1;
                        Z_DTACK_N <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus random contests
// against a transaction-level model with an address-keyed I/O slave.
module tb_io_bus_arbiter;
    localparam int TIMEOUT = 16;

    logic       CLK = 1'b0;
    logic       RESET_N, CE;
    logic       M_SEL, M_RNW, M_DTACK_N;
    logic [3:0] M_A;
    logic [7:0] M_DI, M_DO;
    logic       Z_SEL, Z_RNW, Z_DTACK_N;
    logic [3:0] Z_A;
    logic [7:0] Z_DI, Z_DO;
    logic       IO_SEL, IO_RNW, IO_DTACK_N;
    logic [3:0] IO_A;
    logic [7:0] IO_DI, IO_DO;

    int         n_checks = 0;
    int         n_fail = 0;
    int         ce_div = 1;
    int         sel_cnt = 0;
    int         dly[16];
    logic [7:0] rdv[16];
    logic [7:0] mdl_do[2];
    bit         mdl_ok[2];
    bit         mdl_last_z;

    io_bus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
        .M_SEL(M_SEL), .M_A(M_A), .M_RNW(M_RNW), .M_DI(M_DI), .M_DO(M_DO), .M_DTACK_N(M_DTACK_N),
        .Z_SEL(Z_SEL), .Z_A(Z_A), .Z_RNW(Z_RNW), .Z_DI(Z_DI), .Z_DO(Z_DO), .Z_DTACK_N(Z_DTACK_N),
        .IO_SEL(IO_SEL), .IO_A(IO_A), .IO_RNW(IO_RNW), .IO_DI(IO_DI), .IO_DO(IO_DO),
        .IO_DTACK_N(IO_DTACK_N)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {M_DO, M_DTACK_N, Z_DO, Z_DTACK_N, IO_SEL, IO_A, IO_RNW, IO_DI};
    endfunction

    // Slave acks once IO_SEL has been seen high on dly[IO_A] CE edges.
    task automatic slave_update(input bit pre);
        sel_cnt    = pre ? sel_cnt + 1 : 0;
        IO_DO      = rdv[IO_A];
        IO_DTACK_N = !(IO_SEL && sel_cnt >= dly[IO_A]);
    endtask

    task automatic tick();
        logic [31:0] snap;
        logic        pre;
        for (int i = 1; i < ce_div; i++) begin
            CE   = 1'b0;
            snap = outs();
            @(posedge CLK); #1;
            check("ce0_hold", outs(), snap);
        end
        CE  = 1'b1;
        pre = IO_SEL;
        @(posedge CLK); #1;
        slave_update(pre);
        check("dtack_excl", 32'(M_DTACK_N | Z_DTACK_N), 32'd1);
    endtask

    function automatic int exp_lat(input int d);
        int e;
        e = (d < TIMEOUT) ? d : TIMEOUT;
        if (e < 1) e = 1;
        return 2 + e;
    endfunction

    function automatic bit pick_z(input bit m, input bit z);
`ifdef ARB_ROUND_ROBIN_EN
        if (m && z) return !mdl_last_z;
`endif
        return z && !m;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_mdt"}, 32'(M_DTACK_N), 32'd1);
        check({tag, "_zdt"}, 32'(Z_DTACK_N), 32'd1);
        check({tag, "_mdo"}, 32'(M_DO), 32'hFF);
        check({tag, "_zdo"}, 32'(Z_DO), 32'hFF);
        check({tag, "_iosel"}, 32'(IO_SEL), 32'd0);
        check({tag, "_ioa"}, 32'(IO_A), 32'd0);
        check({tag, "_iornw"}, 32'(IO_RNW), 32'd1);
        check({tag, "_iodi"}, 32'(IO_DI), 32'd0);
        mdl_do[0] = 8'hFF; mdl_do[1] = 8'hFF;
        mdl_ok[0] = 1'b1;  mdl_ok[1] = 1'b1;
        mdl_last_z = 1'b1;
    endtask

    task automatic set_m(input logic [3:0] a, input bit rnw, input logic [7:0] di);
        M_A = a; M_RNW = rnw; M_DI = di;
    endtask

    task automatic set_z(input logic [3:0] a, input bit rnw, input logic [7:0] di);
        Z_A = a; Z_RNW = rnw; Z_DI = di;
    endtask

    // Serve one access of the given master from IDLE to its release.
    task automatic serve(input bit is_z, input int hold, input string tag);
        logic [3:0] a;
        logic       rnw;
        logic [7:0] di, exp_do;
        int         lat, n;
        bit         got, seen_io;
        a   = is_z ? Z_A : M_A;
        rnw = is_z ? Z_RNW : M_RNW;
        di  = is_z ? Z_DI : M_DI;
        exp_do = (rnw && dly[a] <= TIMEOUT) ? rdv[a] : 8'hFF;
        lat = exp_lat(dly[a]);
        n = 0; got = 0; seen_io = 0;
        while (!got && n < lat + 40) begin
            tick();
            n++;
            if (IO_SEL && !seen_io) begin
                seen_io = 1;
                check({tag, "_io_a"}, 32'(IO_A), 32'(a));
                check({tag, "_io_rnw"}, 32'(IO_RNW), 32'(rnw));
                if (!rnw) check({tag, "_io_di"}, 32'(IO_DI), 32'(di));
            end
            if ((is_z ? Z_DTACK_N : M_DTACK_N) == 1'b0) got = 1;
        end
        check({tag, "_seen_io"}, 32'(seen_io), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        if (got) begin
            check({tag, "_do"}, 32'(is_z ? Z_DO : M_DO), 32'(exp_do));
            check({tag, "_other_dt"}, 32'(is_z ? M_DTACK_N : Z_DTACK_N), 32'd1);
            check({tag, "_iosel_done"}, 32'(IO_SEL), 32'd0);
            if (mdl_ok[!is_z])
                check({tag, "_other_do"}, 32'(is_z ? M_DO : Z_DO), 32'(mdl_do[!is_z]));
        end
        mdl_do[is_z] = exp_do;
        mdl_ok[is_z] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold"}, 32'(is_z ? Z_DTACK_N : M_DTACK_N), 32'd0);
        end
        if (is_z) Z_SEL = 1'b0; else M_SEL = 1'b0;
        tick();
        check({tag, "_release"}, 32'(is_z ? Z_DTACK_N : M_DTACK_N), 32'd1);
    endtask

    task automatic contest(input bit m, input bit z, input string tag);
        bit first_z;
        M_SEL = m; Z_SEL = z;
        first_z = pick_z(m, z);
        mdl_last_z = first_z;
        serve(first_z, 0, {tag, first_z ? "_z1" : "_m1"});
        if (m && z) begin
            mdl_last_z = !first_z;
            serve(!first_z, 0, {tag, first_z ? "_m2" : "_z2"});
        end
    endtask

    initial begin
        int         opts[9];
        int         n;
        logic [1:0] pat;
        opts = '{0, 1, 2, 3, 7, 15, 16, 17, 300};
        for (int i = 0; i < 16; i++) begin
            dly[i] = 1;
            rdv[i] = 8'($urandom_range(255));
        end
        RESET_N = 1'b0; CE = 1'b0;
        M_SEL = 1'b0; Z_SEL = 1'b0;
        set_m(4'h0, 1'b1, 8'h00); set_z(4'h0, 1'b1, 8'h00);
        IO_DTACK_N = 1'b1; IO_DO = 8'h00;
        #12;
        check_reset("rst");
        RESET_N = 1'b1;

        // M read, immediate slave
        rdv[1] = 8'h3F; dly[1] = 1;
        set_m(4'h1, 1'b1, 8'h00);
        contest(1'b1, 1'b0, "m_rd");

        // Z write, DTACK held while Z_SEL stays high
        dly[2] = 2;
        set_z(4'h2, 1'b0, 8'h40);
        mdl_last_z = 1'b1;
        Z_SEL = 1'b1;
        serve(1'b1, 3, "z_wr");

        // Simultaneous requests, twice
        set_m(4'h3, 1'b1, 8'h00); set_z(4'h4, 1'b1, 8'h00);
        dly[3] = 0; dly[4] = 3;
        contest(1'b1, 1'b1, "both_a");
        contest(1'b1, 1'b1, "both_b");

        // Timeout boundaries: ack on the last tick wins, one tick later loses
        dly[5] = 300; dly[6] = 16; dly[8] = 17; dly[9] = 15;
        set_m(4'h5, 1'b1, 8'h00); contest(1'b1, 1'b0, "to_never");
        set_m(4'h6, 1'b1, 8'h00); contest(1'b1, 1'b0, "to_d16");
        set_m(4'h8, 1'b1, 8'h00); contest(1'b1, 1'b0, "to_d17");
        set_z(4'h9, 1'b1, 8'h00); contest(1'b0, 1'b1, "to_d15");

        // Abort: M withdraws in WAIT, access completes without DTACK
        dly[3] = 2;
        set_m(4'h3, 1'b1, 8'h00);
        M_SEL = 1'b1;
        mdl_last_z = 1'b0;
        tick(); tick();
        M_SEL = 1'b0;
        n = 0;
        while (IO_SEL && n < 30) begin
            tick();
            n++;
            check("abort_no_dt", 32'(M_DTACK_N), 32'd1);
        end
        check("abort_ticks", 32'(n), 32'd2);
        tick();
        check("abort_idle_dt", 32'(M_DTACK_N), 32'd1);
        mdl_ok[0] = 1'b0;
        set_m(4'h1, 1'b1, 8'h00);
        contest(1'b1, 1'b0, "post_abort");

        // Quarter-rate CE
        ce_div = 4;
        dly[4] = 1;
        set_m(4'h4, 1'b1, 8'h00); contest(1'b1, 1'b0, "ce4_m");
        set_z(4'hA, 1'b0, 8'h5A); contest(1'b0, 1'b1, "ce4_z");
        set_m(4'h1, 1'b1, 8'h00); set_z(4'h2, 1'b1, 8'h00);
        contest(1'b1, 1'b1, "ce4_both");
        ce_div = 1;

        // Async reset during WAIT, then pending M_SEL re-arbitrated
        dly[7] = 300;
        set_m(4'h7, 1'b1, 8'h00);
        M_SEL = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_iosel", 32'(IO_SEL), 32'd1);
        #2 RESET_N = 1'b0;
        #1 check_reset("mid_rst");
        dly[7] = 1;
        #5 RESET_N = 1'b1;
        slave_update(1'b0);
        mdl_last_z = 1'b0;
        serve(1'b0, 0, "after_rst");

        // Random contests
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 16; i++) begin
                dly[i] = opts[$urandom_range(8)];
                rdv[i] = 8'($urandom_range(255));
            end
            pat = 2'($urandom_range(1, 3));
            set_m(4'($urandom_range(15)), 1'($urandom_range(1)), 8'($urandom_range(255)));
            set_z(4'($urandom_range(15)), 1'($urandom_range(1)), 8'($urandom_range(255)));
            contest(pat[0], pat[1], "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
Shares the single controller-port I/O block (the multitap/gen_io register window at A[4:1]) between two bus masters: the 68K and the Z80 through its banked window. The arbiter serialises accesses, drives one request at a time into the I/O block's SEL/A/RNW/DI/DTACK_N interface, and returns data and DTACK_N to the winning master. A timeout guards against an I/O slave that never acknowledges.

Parameters:
TIMEOUT, 16, CE ticks to wait for IO_DTACK_N before forcing completion (1..255)
TO_W, 8, timeout counter width

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
CE  in  1  clock enable; the FSM and timeout advance only when CE=1
M_SEL  in  1  68K request (level, held until DTACK seen)
M_A  in  4  68K address [4:1]
M_RNW  in  1  68K read=1 / write=0
M_DI  in  8  68K write data
M_DO  out  8  68K read data
M_DTACK_N  out  1  68K acknowledge, active low
Z_SEL, Z_A, Z_RNW, Z_DI, Z_DO, Z_DTACK_N  same as M_*, for the Z80 requester
IO_SEL  out  1  request to the I/O block
IO_A  out  4  latched address
IO_RNW  out  1  latched direction
IO_DI  out  8  latched write data
IO_DO  in  8  I/O block read data
IO_DTACK_N  in  1  I/O block acknowledge, active low

Behaviour:
- Reset (async, RESET_N=0): state IDLE; M_DTACK_N=Z_DTACK_N=1; M_DO=Z_DO=8'hFF; IO_SEL=0, IO_A=0, IO_RNW=1, IO_DI=0; timeout counter=0; last_grant=Z (so the first contest goes to M). Reset mid-access aborts immediately; nothing is acknowledged.
- All registers update on rising CLK edges with CE=1 only; outputs hold when CE=0.
- FSM IDLE: if M_SEL or Z_SEL: choose a winner (fixed M priority; see Optional Feature), latch the winner's A/RNW/DI into IO_A/IO_RNW/IO_DI, record grant, go to ISSUE. Otherwise stay.
- ISSUE: IO_SEL=1 (one CE tick of address/data setup); clear the counter; go to WAIT.
- WAIT: IO_SEL=1. If IO_DTACK_N=0: when IO_RNW=1, capture IO_DO into rdata, else rdata=8'hFF; go to DONE. Otherwise increment the counter. When the counter reaches TIMEOUT-1 without an ack, set rdata=8'hFF and go to DONE (ack takes precedence if both occur on the same tick).
- DONE: IO_SEL=0. The winner's DTACK_N=0 and DO=rdata (registered). Stay until the winner's SEL=0, then on the next tick set DTACK_N=1 and go to IDLE. Minimum M_SEL-to-DTACK latency is 3 CE ticks (IDLE→ISSUE→WAIT with immediate ack→DONE).
- Loser: DTACK_N stays 1; its request stays pending and is served on the next IDLE pass. The non-granted DO holds its last value.
- Winner drops SEL during ISSUE/WAIT (abort): the I/O access completes normally; in DONE with SEL already 0 no DTACK is issued and the FSM returns to IDLE after 1 tick.
- Simultaneous M_SEL/Z_SEL in IDLE: exactly one grant, with no cycle where both DTACK_N are low.
- Back-to-back requests from the same master require SEL to deassert first; a new access cannot start from DONE.

Optional Feature:
ARB_ROUND_ROBIN_EN: when defined, a contest in IDLE is granted to the master not recorded in last_grant (alternation); last_grant updates on each grant. When undefined, M always wins a contest and Z is served only when M_SEL=0 in IDLE. Single-requester behaviour is identical in both builds.

Test Plan:
- M read, A=1, IO_DTACK_N low 1 tick after IO_SEL, IO_DO=8'h3F -> IO_A=1, IO_RNW=1; M_DTACK_N=0 with M_DO=8'h3F on the 3rd CE tick after M_SEL; Z_DTACK_N stays 1.
- Z write, A=2, DI=8'h40 -> IO_DI=8'h40, IO_RNW=0 during IO_SEL; Z_DTACK_N low until Z_SEL drops, then 1 on the next tick; Z_DO=8'hFF.
- M_SEL and Z_SEL rise together, default build -> M served first, Z served after M_SEL falls; with ARB_ROUND_ROBIN_EN, after reset M first, then Z, then a repeated simultaneous contest goes to M.
- IO_DTACK_N held high, TIMEOUT=16 -> DTACK returned with DO=8'hFF exactly 16 CE ticks after entering WAIT; IO_SEL=0 in DONE.
- CE toggling at 1/4 rate -> same sequence with latencies scaled by 4 CLKs; no state change on CE=0 cycles.
- RESET_N pulsed low during WAIT -> all outputs return to reset values asynchronously; the pending M_SEL is re-arbitrated from IDLE after release and completes normally.
